fpnew_opgroup_out_fifo: RTL and testbench

- Registered output buffer placed directly downstream of an opgroup block's arbitrated output, before the top-level opgroup output arbiter.
- Decouples the opgroup's valid/ready handshake from the top-level arbiter with a Depth-entry FIFO of {result, status, ext_bit, tag}.
- Keeps a sticky accumulation of status flags for all results delivered downstream, clearable by software/control.

---
 rtl/fpnew_opgroup_out_fifo.sv | 127 ++++++++++++
 tb/tb_fpnew_opgroup_out_fifo.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_opgroup_out_fifo.sv
// Registered output buffer between an opgroup's arbitrated output and the top-level arbiter.
// Holds {result, status, ext_bit, tag} in a small FIFO and accumulates sticky status flags of delivered results.
module fpnew_opgroup_out_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 2,
    parameter type TagType = logic,
    localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [Width-1:0]    in_result_i,
    input  logic [4:0]          in_status_i,
    input  logic                in_ext_bit_i,
    input  TagType              in_tag_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic                flush_i,
    output logic [Width-1:0]    out_result_o,
    output logic [4:0]          out_status_o,
    output logic                out_ext_bit_o,
    output TagType              out_tag_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    input  logic                fflags_clr_i,
    output logic [4:0]          fflags_o,
    output logic [CntWidth-1:0] count_o,
    output logic                busy_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

    if (Depth < 1 || Depth > 16) begin : g_bad_depth
        $error("fpnew_opgroup_out_fifo: Depth must be within 1..16");
    end

    // Explicit wrap so non-power-of-2 depths never index past the last entry.
    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
        if (ptr == PtrWidth'(Depth - 1)) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    logic [Width-1:0]    result_q [Depth];
    logic [4:0]          status_q [Depth];
    logic                ext_bit_q[Depth];
    TagType              tag_q    [Depth];

    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [4:0]          fflags_q, fflags_d;
    logic                push, pop;

    assign in_ready_o    = (cnt_q != CntWidth'(Depth));
    assign out_valid_o   = (cnt_q != '0);
    assign busy_o        = (cnt_q != '0);
    assign count_o       = cnt_q;
    assign fflags_o      = fflags_q;

    assign out_result_o  = result_q[rd_ptr_q];
    assign out_status_o  = status_q[rd_ptr_q];
    assign out_ext_bit_o = ext_bit_q[rd_ptr_q];
    assign out_tag_o     = tag_q[rd_ptr_q];

    // A flush swallows both handshakes of the same cycle.
    assign push = in_valid_i & in_ready_o & ~flush_i;
    assign pop  = out_valid_o & out_ready_i & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                cnt_d = cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Clear acts on the old accumulator value; a same-cycle pop still merges its flags.
    always_comb begin
        fflags_d = fflags_q;
        if (fflags_clr_i) begin
            fflags_d = pop ? out_status_o : 5'b0;
        end else if (pop) begin
            fflags_d = fflags_q | out_status_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            fflags_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            fflags_q <= fflags_d;
        end
    end

    // Entry storage carries data only and is left unreset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            result_q[wr_ptr_q]  <= in_result_i;
            status_q[wr_ptr_q]  <= in_status_i;
            ext_bit_q[wr_ptr_q] <= in_ext_bit_i;
            tag_q[wr_ptr_q]     <= in_tag_i;
        end
    end

endmodule

// File: tb/tb_fpnew_opgroup_out_fifo.sv
// Directed bench for fpnew_opgroup_out_fifo: a Depth=2 instance for handshake/flag/flush cases
// and a Depth=3 instance for in-order streaming across pointer wrap.
module tb_fpnew_opgroup_out_fifo;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] a_in_res, a_out_res;
    logic [4:0]  a_in_st, a_out_st, a_ff;
    logic        a_in_ext, a_out_ext;
    logic [7:0]  a_in_tag, a_out_tag;
    logic        a_in_vld, a_in_rdy, a_flush, a_out_vld, a_out_rdy, a_clr, a_busy;
    logic [1:0]  a_cnt;

    logic [31:0] b_in_res, b_out_res;
    logic [4:0]  b_in_st, b_out_st, b_ff;
    logic        b_in_ext, b_out_ext;
    logic [7:0]  b_in_tag, b_out_tag;
    logic        b_in_vld, b_in_rdy, b_flush, b_out_vld, b_out_rdy, b_clr, b_busy;
    logic [1:0]  b_cnt;

    fpnew_opgroup_out_fifo #(.Width(32), .Depth(2), .TagType(logic [7:0])) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .in_result_i(a_in_res), .in_status_i(a_in_st), .in_ext_bit_i(a_in_ext),
        .in_tag_i(a_in_tag), .in_valid_i(a_in_vld), .in_ready_o(a_in_rdy),
        .flush_i(a_flush),
        .out_result_o(a_out_res), .out_status_o(a_out_st), .out_ext_bit_o(a_out_ext),
        .out_tag_o(a_out_tag), .out_valid_o(a_out_vld), .out_ready_i(a_out_rdy),
        .fflags_clr_i(a_clr), .fflags_o(a_ff), .count_o(a_cnt), .busy_o(a_busy)
    );

    fpnew_opgroup_out_fifo #(.Width(32), .Depth(3), .TagType(logic [7:0])) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .in_result_i(b_in_res), .in_status_i(b_in_st), .in_ext_bit_i(b_in_ext),
        .in_tag_i(b_in_tag), .in_valid_i(b_in_vld), .in_ready_o(b_in_rdy),
        .flush_i(b_flush),
        .out_result_o(b_out_res), .out_status_o(b_out_st), .out_ext_bit_o(b_out_ext),
        .out_tag_o(b_out_tag), .out_valid_o(b_out_vld), .out_ready_i(b_out_rdy),
        .fflags_clr_i(b_clr), .fflags_o(b_ff), .count_o(b_cnt), .busy_o(b_busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  sent;
        int  got;
        logic [7:0] q[$];

        a_in_res = '0; a_in_st = '0; a_in_ext = 1'b0; a_in_tag = '0;
        a_in_vld = 1'b0; a_flush = 1'b0; a_out_rdy = 1'b0; a_clr = 1'b0;
        b_in_res = '0; b_in_st = '0; b_in_ext = 1'b0; b_in_tag = '0;
        b_in_vld = 1'b0; b_flush = 1'b0; b_out_rdy = 1'b0; b_clr = 1'b0;

        // Reset state
        #12;
        chk("rst_in_ready", a_in_rdy, 1);
        chk("rst_out_valid", a_out_vld, 0);
        chk("rst_count", a_cnt, 0);
        chk("rst_fflags", a_ff, 5'b0);
        chk("rst_busy", a_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle_in_ready", a_in_rdy, 1);
        chk("idle_out_valid", a_out_vld, 0);

        // Single push, no fall-through, pop next cycle
        a_in_vld = 1'b1; a_in_res = 32'h3F80_0000; a_in_tag = 8'd1; a_in_st = 5'b00001;
        a_out_rdy = 1'b1;
        tick();
        a_in_vld = 1'b0;
        chk("one_valid", a_out_vld, 1);
        chk("one_result", a_out_res, 32'h3F80_0000);
        chk("one_tag", a_out_tag, 8'd1);
        tick();
        chk("one_count", a_cnt, 0);
        chk("one_fflags", a_ff, 5'b00001);

        // Back-pressure: third push refused while full, head stable
        a_out_rdy = 1'b0; a_in_st = 5'b0;
        a_in_vld = 1'b1; a_in_tag = 8'd1; a_in_res = 32'hA1;
        tick();
        chk("bp_count1", a_cnt, 1);
        chk("bp_ready1", a_in_rdy, 1);
        a_in_tag = 8'd2; a_in_res = 32'hA2;
        tick();
        chk("bp_count2", a_cnt, 2);
        chk("bp_ready_full", a_in_rdy, 0);
        a_in_tag = 8'd3; a_in_res = 32'hA3;
        tick();
        a_in_vld = 1'b0;
        chk("bp_count_still2", a_cnt, 2);
        chk("bp_head_tag", a_out_tag, 8'd1);
        chk("bp_head_res", a_out_res, 32'hA1);
        tick();
        chk("bp_head_stable", a_out_tag, 8'd1);
        chk("bp_valid_stable", a_out_vld, 1);
        a_out_rdy = 1'b1;
        tick();
        chk("bp_pop1_count", a_cnt, 1);
        chk("bp_pop1_ready", a_in_rdy, 1);
        chk("bp_pop2_tag", a_out_tag, 8'd2);
        chk("bp_pop2_res", a_out_res, 32'hA2);
        tick();
        chk("bp_empty_valid", a_out_vld, 0);
        chk("bp_empty_count", a_cnt, 0);
        a_out_rdy = 1'b0;

        // Depth=3 streaming with toggling out_ready
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 100 && got < 10; cyc++) begin
            b_in_vld  = (sent < 10);
            b_in_tag  = 8'(sent);
            b_in_res  = 32'(sent) + 32'h100;
            b_out_rdy = (cyc % 2 == 0);
            if (b_in_vld && b_in_rdy) begin
                q.push_back(8'(sent));
                sent++;
            end
            if (b_out_vld && b_out_rdy) begin
                if (q.size() == 0) begin
                    chk("b_spurious_pop", 1, 0);
                end else begin
                    chk("b_order", b_out_tag, q.pop_front());
                end
                got++;
            end
            tick();
        end
        b_in_vld = 1'b0; b_out_rdy = 1'b0;
        chk("b_all_popped", got, 10);
        chk("b_count_end", b_cnt, 0);

        // Sticky flags with clear coinciding with a pop (accumulator holds 00001 here)
        a_in_vld = 1'b1; a_in_st = 5'b10000; a_in_tag = 8'd4;
        tick();
        a_in_st = 5'b00100; a_in_tag = 8'd5;
        tick();
        a_in_vld = 1'b0;
        chk("ff_count2", a_cnt, 2);
        chk("ff_before", a_ff, 5'b00001);
        a_out_rdy = 1'b1; a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        chk("ff_clr_pop", a_ff, 5'b10000);
        tick();
        chk("ff_merge", a_ff, 5'b10100);
        chk("ff_empty", a_cnt, 0);
        a_out_rdy = 1'b0;

        // Flush with simultaneous push and pop
        a_in_vld = 1'b1; a_in_st = 5'b01000; a_in_tag = 8'd6;
        tick();
        a_in_tag = 8'd7;
        tick();
        chk("fl_count2", a_cnt, 2);
        a_flush = 1'b1; a_in_st = 5'b00010; a_in_tag = 8'd8; a_out_rdy = 1'b1;
        tick();
        a_flush = 1'b0; a_in_vld = 1'b0; a_out_rdy = 1'b0;
        chk("fl_count", a_cnt, 0);
        chk("fl_valid", a_out_vld, 0);
        chk("fl_busy", a_busy, 0);
        chk("fl_fflags", a_ff, 5'b10100);
        chk("fl_ready", a_in_rdy, 1);
        a_in_vld = 1'b1; a_in_tag = 8'd9; a_in_res = 32'h9;
        tick();
        a_in_vld = 1'b0;
        chk("fl_after_tag", a_out_tag, 8'd9);
        chk("fl_after_res", a_out_res, 32'h9);
        chk("fl_after_count", a_cnt, 1);

        // Asynchronous reset between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", a_cnt, 0);
        chk("arst_valid", a_out_vld, 0);
        chk("arst_ready", a_in_rdy, 1);
        chk("arst_fflags", a_ff, 5'b0);
        chk("arst_busy", a_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
